// File: rtl/run_sort_checker.sv
// run_sort_checker: watches pc for a halt loop or timeout, then checks that the
// first CHECK_LEN words are ascending. Optional checksum: RUN_SORT_CHECKER_SUM_EN.
module run_sort_checker #(
    parameter int MEM_BYTES      = 16,
    parameter int WORD_W         = 8,
    parameter int CHECK_LEN      = 8,
    parameter int PC_W           = 6,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int EXP_SUM        = 36
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MEM_BYTES*WORD_W-1:0]   data,
    input  logic [PC_W-1:0]               pc,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [$clog2(MEM_BYTES)-1:0]  fail_idx,
    output logic [15:0]                   cycles,
    output logic                          sum_err
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int SC_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SUM_W = WORD_W + $clog2(CHECK_LEN);

    if (CHECK_LEN < 2 || CHECK_LEN > MEM_BYTES) begin : g_bad_len
        $error("CHECK_LEN out of range");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (EXP_SUM < 0 || EXP_SUM >= (1 << SUM_W)) begin : g_bad_sum
        $error("EXP_SUM does not fit the checksum register");
    end

    typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [IDX_W-1:0]    r_fail_idx;
    logic [15:0]         r_cycles;
    logic [SC_W-1:0]     r_stable;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [PC_W-1:0]     r_pc_prev;
    logic                r_first;

    logic [WORD_W-1:0]   w_words [MEM_BYTES];
    logic [IDX_W-1:0]    w_idx_b;
    logic [WORD_W-1:0]   w_word_a;
    logic [WORD_W-1:0]   w_word_b;
    logic                w_halt;
    logic                w_tmo;
    logic                w_gt;
    logic                w_last;

    for (genvar g = 0; g < MEM_BYTES; g++) begin : g_words
        assign w_words[g] = data[g*WORD_W +: WORD_W];
    end

    assign w_idx_b  = r_scan_idx + IDX_W'(1);
    assign w_word_a = w_words[r_scan_idx];
    assign w_word_b = w_words[w_idx_b];
    assign w_halt   = (r_stable == SC_W'(STABLE_CYCLES));
    assign w_tmo    = (r_cycles == 16'(TIMEOUT_CYCLES - 1));
    assign w_gt     = (w_word_a > w_word_b);
    assign w_last   = (r_scan_idx == IDX_W'(CHECK_LEN - 2));

    assign busy     = (r_state == RUN) || (r_state == SCAN);
    assign done     = r_done;
    assign pass     = r_pass;
    assign timeout  = r_timeout;
    assign fail_idx = r_fail_idx;
    assign cycles   = r_cycles;

`ifdef RUN_SORT_CHECKER_SUM_EN
    logic [SUM_W-1:0]    r_sum;
    logic                r_sum_err;
    logic [SUM_W-1:0]    w_sum_fin;

    assign w_sum_fin = r_sum + SUM_W'(w_word_a) + SUM_W'(w_word_b);
    assign sum_err   = r_sum_err;
`else
    assign sum_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a halt seen on the timeout cycle still goes to SCAN
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                if (w_halt)     w_next = SCAN;
                else if (w_tmo) w_next = DONE;
            end
            SCAN: begin
                if (w_gt || w_last) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Run counters, pair scan and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_fail_idx <= '0;
            r_cycles   <= '0;
            r_stable   <= '0;
            r_scan_idx <= '0;
            r_pc_prev  <= '0;
            r_first    <= 1'b0;
`ifdef RUN_SORT_CHECKER_SUM_EN
            r_sum      <= '0;
            r_sum_err  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_fail_idx <= '0;
                        r_cycles   <= '0;
                        r_stable   <= '0;
                        r_scan_idx <= '0;
                        r_first    <= 1'b1;
`ifdef RUN_SORT_CHECKER_SUM_EN
                        r_sum      <= '0;
                        r_sum_err  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_pc_prev <= pc;
                    r_first   <= 1'b0;
                    if (r_first)              r_stable <= '0;
                    else if (pc == r_pc_prev) r_stable <= r_stable + SC_W'(1);
                    else                      r_stable <= '0;
                    if (w_halt) begin
                        r_cycles <= r_cycles;
                    end else if (w_tmo) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (r_cycles != 16'hFFFF) begin
                        r_cycles <= r_cycles + 16'd1;
                    end
                end
                SCAN: begin
                    r_scan_idx <= w_idx_b;
`ifdef RUN_SORT_CHECKER_SUM_EN
                    r_sum      <= r_sum + SUM_W'(w_word_a);
`endif
                    if (w_gt) begin
                        r_done     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_fail_idx <= r_scan_idx;
                    end else if (w_last) begin
                        r_done <= 1'b1;
`ifdef RUN_SORT_CHECKER_SUM_EN
                        if (w_sum_fin != SUM_W'(EXP_SUM)) begin
                            r_pass     <= 1'b0;
                            r_sum_err  <= 1'b1;
                            r_fail_idx <= IDX_W'(CHECK_LEN - 1);
                        end else begin
                            r_pass <= 1'b1;
                        end
`else
                        r_pass <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sort_checker.sv
// tb_run_sort_checker: directed scenarios for run_sort_checker (default parameters).
// Expected latencies are counted in clock edges after the start edge.
module tb_run_sort_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data;
    logic [5:0]   pc;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic [3:0]   fail_idx;
    logic [15:0]  cycles;
    logic         sum_err;

    int n_cmp = 0;
    int n_bad = 0;

    run_sort_checker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .fail_idx (fail_idx),
        .cycles   (cycles),
        .sum_err  (sum_err)
    );

    always #5 clk = ~clk;

    // pc pattern for RUN cycle j
    function automatic logic [5:0] pc_of(input int mode, input int j);
        case (mode)
            0:       return (j < 100) ? 6'(j % 2) : 6'd42;
            1:       return 6'd42;
            2:       return 6'(j);
            default: return (j < 2990) ? 6'(j) : 6'd42;
        endcase
    endfunction

    // Pulse start, drive pc per cycle; lat = edges after start edge until done, -1 if bound hit
    task automatic run_prog(input int mode, input int pulse_at, input int bound, output int lat);
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        pc    = pc_of(mode, 0);
        @(posedge clk);
        for (int j = 0; j < bound; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j;
                break;
            end
            start = (j == pulse_at);
            pc    = pc_of(mode, j);
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        pc    = '0;
        data  = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %0b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset pass: got %0b want 0", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset timeout: got %0b want 0", timeout); end
        n_cmp++; if (fail_idx !== 4'd0) begin n_bad++; $display("FAIL reset fail_idx: got %0d want 0", fail_idx); end
        n_cmp++; if (cycles !== 16'd0) begin n_bad++; $display("FAIL reset cycles: got %0d want 0", cycles); end
        n_cmp++; if (sum_err !== 1'b0) begin n_bad++; $display("FAIL reset sum_err: got %0b want 0", sum_err); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle busy: got %0b want 0", busy); end
    endtask

    task automatic test_sorted();
        int lat;
        data = {64'h0, 64'h0807060504030201};
        run_prog(0, -1, 200, lat);
        n_cmp++; if (lat !== 117) begin n_bad++; $display("FAIL sorted latency: got %0d want 117", lat); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL sorted pass: got %0b want 1", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL sorted timeout: got %0b want 0", timeout); end
        n_cmp++; if (fail_idx !== 4'd0) begin n_bad++; $display("FAIL sorted fail_idx: got %0d want 0", fail_idx); end
        n_cmp++; if (cycles !== 16'd109) begin n_bad++; $display("FAIL sorted cycles: got %0d want 109", cycles); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sorted busy: got %0b want 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sorted done hold: got %0b want 1", done); end
    endtask

    task automatic test_unsorted();
        int lat;
        data = {64'h0, 64'h0807060403050201};
        run_prog(1, -1, 60, lat);
        n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL unsorted latency: got %0d want 13", lat); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL unsorted pass: got %0b want 0", pass); end
        n_cmp++; if (fail_idx !== 4'd2) begin n_bad++; $display("FAIL unsorted fail_idx: got %0d want 2", fail_idx); end
        n_cmp++; if (cycles !== 16'd9) begin n_bad++; $display("FAIL unsorted cycles: got %0d want 9", cycles); end
        n_cmp++; if (sum_err !== 1'b0) begin n_bad++; $display("FAIL unsorted sum_err: got %0b want 0", sum_err); end
    endtask

    task automatic test_pair_edges();
        int lat;
        data = {64'h0, 64'h0807060504030180};
        run_prog(1, -1, 60, lat);
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL first pair latency: got %0d want 11", lat); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL first pair pass: got %0b want 0", pass); end
        n_cmp++; if (fail_idx !== 4'd0) begin n_bad++; $display("FAIL first pair fail_idx: got %0d want 0", fail_idx); end
        data = {64'h0, 64'h0708060504030201};
        run_prog(1, -1, 60, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL last pair latency: got %0d want 17", lat); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL last pair pass: got %0b want 0", pass); end
        n_cmp++; if (fail_idx !== 4'd6) begin n_bad++; $display("FAIL last pair fail_idx: got %0d want 6", fail_idx); end
        n_cmp++; if (sum_err !== 1'b0) begin n_bad++; $display("FAIL last pair sum_err: got %0b want 0", sum_err); end
        data = {64'h0, 64'h0907060504030101};
        run_prog(1, -1, 60, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL equal pair latency: got %0d want 17", lat); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL equal pair pass: got %0b want 1", pass); end
    endtask

    task automatic test_timeout();
        int lat;
        data = {64'h0, 64'h0807060504030201};
        run_prog(2, -1, 3100, lat);
        n_cmp++; if (lat !== 3000) begin n_bad++; $display("FAIL timeout latency: got %0d want 3000", lat); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout flag: got %0b want 1", timeout); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL timeout pass: got %0b want 0", pass); end
        n_cmp++; if (cycles !== 16'd2999) begin n_bad++; $display("FAIL timeout cycles: got %0d want 2999", cycles); end
        n_cmp++; if (fail_idx !== 4'd0) begin n_bad++; $display("FAIL timeout fail_idx: got %0d want 0", fail_idx); end
    endtask

    task automatic test_collision();
        int lat;
        data = {64'h0, 64'h0807060504030201};
        run_prog(3, -1, 3100, lat);
        n_cmp++; if (lat !== 3007) begin n_bad++; $display("FAIL collision latency: got %0d want 3007", lat); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL collision timeout: got %0b want 0", timeout); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL collision pass: got %0b want 1", pass); end
        n_cmp++; if (cycles !== 16'd2999) begin n_bad++; $display("FAIL collision cycles: got %0d want 2999", cycles); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        data = {64'h0, 64'h0807060504030201};
        run_prog(1, -1, 12, lat);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid scan busy: got %0b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async rst busy: got %0b want 0", busy); end
        n_cmp++; if (cycles !== 16'd0) begin n_bad++; $display("FAIL async rst cycles: got %0d want 0", cycles); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL async rst done: got %0b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post rst idle: got %0b want 0", busy); end
        run_prog(1, 3, 60, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL rerun latency: got %0d want 17", lat); end
        n_cmp++; if (cycles !== 16'd9) begin n_bad++; $display("FAIL rerun cycles: got %0d want 9", cycles); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL rerun pass: got %0b want 1", pass); end
    endtask

    task automatic test_sum();
        int lat;
        data = {64'h0, 64'h0907060504030201};
        run_prog(1, -1, 60, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL sum latency: got %0d want 17", lat); end
`ifdef RUN_SORT_CHECKER_SUM_EN
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL sum pass: got %0b want 0", pass); end
        n_cmp++; if (sum_err !== 1'b1) begin n_bad++; $display("FAIL sum sum_err: got %0b want 1", sum_err); end
        n_cmp++; if (fail_idx !== 4'd7) begin n_bad++; $display("FAIL sum fail_idx: got %0d want 7", fail_idx); end
`else
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL sum pass: got %0b want 1", pass); end
        n_cmp++; if (sum_err !== 1'b0) begin n_bad++; $display("FAIL sum sum_err: got %0b want 0", sum_err); end
        n_cmp++; if (fail_idx !== 4'd0) begin n_bad++; $display("FAIL sum fail_idx: got %0d want 0", fail_idx); end
`endif
    endtask

    initial begin
        test_reset();
        test_sorted();
        test_unsorted();
        test_pair_edges();
        test_timeout();
        test_collision();
        test_reset_mid_scan();
        test_sum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
